seg_scan_ctrl: RTL and testbench

Time-multiplexing scheduler that shares one 7-segment cathode bus among `N_DIGITS` digit positions on the board display. It sits between the counter/debounce logic, which writes digit values through a valid/ready port, and the board pins. It holds a shadow and a display register bank, commits the shadow at frame boundaries so updates never tear, and sequences anode strobes with a ghosting guard interval and leading-zero suppression.

---
 rtl/seg_scan_pkg.sv | 21 ++
 rtl/seg7_hex_decode.sv | 12 +
 rtl/seg_scan_ctrl.sv | 157 +++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the multiplexed 7-segment scanner.
// Glyph table is indexed by the 4-bit digit value; bit0 = segment a.
package seg_scan_pkg;

   typedef enum logic [0:0] {
      GUARD = 1'b0,
      ON    = 1'b1
   } scan_state_e;

   localparam int N_DIGITS_DEFAULT = 4;

   localparam logic [6:0] SEG_OFF = 7'b0000000;

   localparam logic [6:0] SEG_HEX [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F,
      7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C,
      7'h39, 7'h5E, 7'h79, 7'h71
   };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex digit to 7-segment glyph, with a blank override.
module seg7_hex_decode
   import seg_scan_pkg::*;
(
   input  logic [3:0] digit,
   input  logic       blank,
   output logic [6:0] seg
);

   assign seg = blank ? SEG_OFF : SEG_HEX[digit];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scanner with shadow/display banks committed per frame.
// Optional blinking is compiled in with the SEG_SCAN_BLINK_EN macro.
module seg_scan_ctrl
   import seg_scan_pkg::*;
#(
   parameter int N_DIGITS     = N_DIGITS_DEFAULT,
   parameter int REFRESH_DIV  = 100000,
   parameter int GUARD_CYCLES = 1000,
   parameter int BLINK_FRAMES = 64
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        wr_valid,
   output logic                        wr_ready,
   input  logic [$clog2(N_DIGITS)-1:0] wr_idx,
   input  logic [3:0]                  wr_digit,
   input  logic [N_DIGITS-1:0]         blank_mask,
   input  logic                        lz_en,
`ifdef SEG_SCAN_BLINK_EN
   input  logic [N_DIGITS-1:0]         blink_mask,
`endif
   output logic [6:0]                  seg,
   output logic [N_DIGITS-1:0]         an,
   output logic                        frame_tick
);

   localparam int SLOT_W = $clog2(N_DIGITS);
   localparam int CNT_W  = $clog2(REFRESH_DIV);
   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(N_DIGITS - 1);
   localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0]  GUARD_END = CNT_W'(GUARD_CYCLES - 1);
   localparam logic [0:0]        S_GUARD   = GUARD;
   localparam logic [0:0]        S_ON      = ON;

   if (GUARD_CYCLES < 1 || GUARD_CYCLES >= REFRESH_DIV || BLINK_FRAMES < 1) begin : g_bad_params
      $error("seg_scan_ctrl: need 1 <= GUARD_CYCLES < REFRESH_DIV and BLINK_FRAMES >= 1");
   end

   logic [0:0]          state;
   logic [SLOT_W-1:0]   slot;
   logic [SLOT_W-1:0]   slot_next;
   logic [CNT_W-1:0]    cnt;
   logic [CNT_W-1:0]    cnt_next;
   logic                ft_next;
   logic [3:0]          shadow [N_DIGITS];
   logic [3:0]          disp   [N_DIGITS];
   logic [N_DIGITS-1:0] upper_zero;
   logic                blink_off;
   logic                dark;
   logic [6:0]          glyph;

   always_comb begin
      cnt_next  = (cnt == LAST_CNT) ? '0 : cnt + 1'b1;
      slot_next = slot;
      if (cnt == LAST_CNT) begin
         slot_next = (slot == LAST_SLOT) ? '0 : slot + 1'b1;
      end
      ft_next = (cnt_next == LAST_CNT) && (slot_next == LAST_SLOT);
   end

   // upper_zero[i]: every committed digit at position i and above is zero.
   always_comb begin
      upper_zero = '0;
      upper_zero[N_DIGITS-1] = (disp[N_DIGITS-1] == 4'd0);
      for (int i = N_DIGITS - 2; i >= 0; i--) begin
         upper_zero[i] = (disp[i] == 4'd0) && upper_zero[i+1];
      end
   end

`ifdef SEG_SCAN_BLINK_EN
   localparam int FRM_W = $clog2(BLINK_FRAMES + 1);
   logic [FRM_W-1:0] frm_cnt;
   logic             blink_phase_off;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frm_cnt         <= '0;
         blink_phase_off <= 1'b0;
      end else if (frame_tick) begin
         if (frm_cnt == FRM_W'(BLINK_FRAMES - 1)) begin
            frm_cnt         <= '0;
            blink_phase_off <= ~blink_phase_off;
         end else begin
            frm_cnt <= frm_cnt + 1'b1;
         end
      end
   end

   assign blink_off = blink_phase_off && blink_mask[slot];
`else
   assign blink_off = 1'b0;
`endif

   assign dark = blank_mask[slot] || (lz_en && (slot != '0) && upper_zero[slot]) || blink_off;

   seg7_hex_decode u_decode (
      .digit (disp[slot]),
      .blank (dark),
      .seg   (glyph)
   );

   // Masks and the glyph are captured once on GUARD->ON and held for the slot.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_GUARD;
         slot       <= '0;
         cnt        <= '0;
         an         <= '1;
         seg        <= SEG_OFF;
         frame_tick <= 1'b0;
         wr_ready   <= 1'b0;
      end else begin
         cnt        <= cnt_next;
         slot       <= slot_next;
         frame_tick <= ft_next;
         wr_ready   <= !ft_next;
         case (state)
            S_GUARD: begin
               if (cnt == GUARD_END) begin
                  state <= S_ON;
                  an    <= ~(N_DIGITS'(1) << slot);
                  seg   <= glyph;
               end
            end
            S_ON: begin
               if (cnt == LAST_CNT) begin
                  state <= S_GUARD;
                  an    <= '1;
                  seg   <= SEG_OFF;
               end
            end
            default: state <= S_GUARD;
         endcase
      end
   end

   // Handshake: a write transfers on any rising edge where wr_valid && wr_ready;
   // wr_ready is low on the frame_tick cycle so a write never races the commit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N_DIGITS; i++) begin
            shadow[i] <= 4'd0;
            disp[i]   <= 4'd0;
         end
      end else begin
         if (wr_valid && wr_ready && (int'(wr_idx) < N_DIGITS)) begin
            shadow[wr_idx] <= wr_digit;
         end
         if (frame_tick) begin
            for (int i = 0; i < N_DIGITS; i++) begin
               disp[i] <= shadow[i];
            end
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: cycle-by-cycle model comparison plus hand-computed pins.
// Blink checks are included when SEG_SCAN_BLINK_EN is defined.
module tb_seg_scan_ctrl;

   localparam int N  = 4;
   localparam int RD = 20;
   localparam int G  = 4;
   localparam int BF = 2;
   localparam int FRAME = N * RD;

   localparam logic [6:0] GLYPH [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         wr_valid = 1'b0;
   logic         wr_ready;
   logic [1:0]   wr_idx = '0;
   logic [3:0]   wr_digit = '0;
   logic [N-1:0] blank_mask = '0;
   logic         lz_en = 1'b0;
   logic [N-1:0] blink_mask = '0;
   logic [6:0]   seg;
   logic [N-1:0] an;
   logic         frame_tick;

   seg_scan_ctrl #(
      .N_DIGITS     (N),
      .REFRESH_DIV  (RD),
      .GUARD_CYCLES (G),
      .BLINK_FRAMES (BF)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .wr_valid   (wr_valid),
      .wr_ready   (wr_ready),
      .wr_idx     (wr_idx),
      .wr_digit   (wr_digit),
      .blank_mask (blank_mask),
      .lz_en      (lz_en),
`ifdef SEG_SCAN_BLINK_EN
      .blink_mask (blink_mask),
`endif
      .seg        (seg),
      .an         (an),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int t = 0;
   int epoch = -1;
   bit in_reset = 1'b0;

   logic [3:0] m_shadow [N];
   logic [3:0] m_disp   [N];
   logic [6:0] m_cap_seg = 7'h00;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (epoch %0d t=%0d)", name, act, exp, epoch, t);
      end
   endtask

   function automatic logic [6:0] model_pattern(input int s, input int frame);
      bit dark;
      bit all_zero;
      dark = blank_mask[s];
      if (lz_en && s != 0) begin
         all_zero = 1'b1;
         for (int j = s; j < N; j++) begin
            if (m_disp[j] != 4'd0) all_zero = 1'b0;
         end
         if (all_zero) dark = 1'b1;
      end
`ifdef SEG_SCAN_BLINK_EN
      if (blink_mask[s] && ((frame / BF) % 2 == 1)) dark = 1'b1;
`endif
      if (frame < 0) dark = 1'b1;
      return dark ? 7'h00 : GLYPH[m_disp[s]];
   endfunction

   // Model: outputs follow from the cycle number since reset release.
   always @(negedge clk) begin
      int pos, slot, frame;
      bit exp_ft, exp_ready;
      logic [N-1:0] exp_an;
      logic [6:0] exp_seg;
      if (rst) begin
         chk("rst_an", an, 4'hF);
         chk("rst_seg", seg, 7'h00);
         chk("rst_frame_tick", frame_tick, 1'b0);
         chk("rst_wr_ready", wr_ready, 1'b0);
         for (int i = 0; i < N; i++) begin
            m_shadow[i] = 4'd0;
            m_disp[i]   = 4'd0;
         end
         m_cap_seg = 7'h00;
         t = 0;
         in_reset = 1'b1;
      end else begin
         if (in_reset) begin
            in_reset = 1'b0;
            epoch++;
         end
         pos       = t % RD;
         slot      = (t / RD) % N;
         frame     = t / FRAME;
         exp_ft    = (t % FRAME) == FRAME - 1;
         exp_ready = (t > 0) && !exp_ft;
         exp_an    = (pos < G) ? 4'hF : (4'hF & ~(4'b0001 << slot));
         exp_seg   = (pos < G) ? 7'h00 : m_cap_seg;
         chk("model_an", an, exp_an);
         chk("model_seg", seg, exp_seg);
         chk("model_frame_tick", frame_tick, exp_ft);
         chk("model_wr_ready", wr_ready, exp_ready);

         if (epoch == 0) begin
            if (t == 3)   chk("pin_an_t3", an, 4'b1111);
            if (t == 4)   chk("pin_an_t4", an, 4'b1110);
            if (t == 19)  chk("pin_an_t19", an, 4'b1110);
            if (t == 20)  chk("pin_an_t20_guard", an, 4'b1111);
            if (t == 24)  chk("pin_an_t24", an, 4'b1101);
            if (t == 78)  chk("pin_ft_t78", frame_tick, 1'b0);
            if (t == 79)  chk("pin_ft_t79", frame_tick, 1'b1);
            if (t == 50)  chk("pin_slot2_before_commit", seg, 7'h3F);
            if (t == 130) chk("pin_slot2_glyph7", seg, 7'b0000111);
            if (t == 159) chk("pin_ready_low_on_tick", wr_ready, 1'b0);
            if (t == 160) chk("pin_ready_after_tick", wr_ready, 1'b1);
            if (t == 190) chk("pin_slot1_not_yet", seg, 7'h3F);
            if (t == 270) chk("pin_slot1_glyph5", seg, 7'h6D);
            if (t == 330) chk("pin_lz_slot0", seg, 7'h3F);
            if (t == 350) chk("pin_lz_slot1", seg, 7'h4F);
            if (t == 370) chk("pin_lz_slot2", seg, 7'h00);
            if (t == 390) chk("pin_lz_slot3", seg, 7'h00);
            if (t == 490) chk("pin_allzero_slot0", seg, 7'h3F);
            if (t == 510) chk("pin_allzero_slot1", seg, 7'h00);
            if (t == 610) chk("pin_blank_slot2", seg, 7'h00);
            if (t == 630) chk("pin_nolz_slot3", seg, 7'h3F);
            if (t == 690) chk("pin_unblank_slotA", seg, 7'h77);
         end else if (epoch == 1) begin
            if (t == 3)   chk("pin_restart_an_t3", an, 4'b1111);
            if (t == 4)   chk("pin_restart_an_t4", an, 4'b1110);
            if (t == 24)  chk("pin_restart_an_t24", an, 4'b1101);
            if (t == 150) chk("pin_restart_slot3_F", seg, 7'h71);
`ifdef SEG_SCAN_BLINK_EN
            if (t % FRAME == 10 && t / FRAME < 6)
               chk("pin_blink_digit0", seg, ((t / FRAME == 2) || (t / FRAME == 3)) ? 7'h00 : 7'h3F);
`endif
         end

         if (wr_valid && exp_ready) m_shadow[wr_idx] = wr_digit;
         if (exp_ft) m_disp = m_shadow;
         if (pos == G - 1) m_cap_seg = model_pattern(slot, frame);
         t++;
      end
   end

   // Waits until cycle tt of the current epoch has begun.
   task automatic goto(input int tt);
      int n;
      n = 0;
      forever begin
         @(posedge clk);
         #1;
         if (t == tt) break;
         n++;
         if (n > 2000) begin
            chk("goto_timeout", t, tt);
            break;
         end
      end
   endtask

   task automatic write(input logic [1:0] idx, input logic [3:0] dig);
      int n;
      wr_valid = 1'b1;
      wr_idx   = idx;
      wr_digit = dig;
      n = 0;
      forever begin
         @(negedge clk);
         if (wr_ready) break;
         n++;
         if (n > 50) begin
            chk("write_timeout", 0, 1);
            break;
         end
      end
      @(posedge clk);
      #1;
      wr_valid = 1'b0;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      goto(10);
      write(2'd2, 4'd7);
      goto(159);
      write(2'd1, 4'd5);
      goto(245);
      write(2'd2, 4'd0);
      write(2'd1, 4'd3);
      write(2'd0, 4'd0);
      write(2'd3, 4'd0);
      goto(300);
      lz_en = 1'b1;
      goto(405);
      write(2'd1, 4'd0);
      goto(485);
      write(2'd2, 4'hA);
      goto(560);
      lz_en = 1'b0;
      blank_mask = 4'b0100;
      goto(640);
      blank_mask = 4'b0000;

      goto(750);
      #3 rst = 1'b1;
      #1;
      chk("async_rst_an", an, 4'hF);
      chk("async_rst_seg", seg, 7'h00);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
`ifdef SEG_SCAN_BLINK_EN
      blink_mask = 4'b0001;
`endif
      goto(20);
      write(2'd3, 4'hF);
`ifdef SEG_SCAN_BLINK_EN
      goto(490);
`else
      goto(170);
`endif
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
